// File: rtl/addsub_issue.sv
// Operand queue feeding an external add/sub unit, with a registered result stage
// and an output handshake. DEPTH operations can wait in the queue plus one held in the output register.
module addsub_issue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_sub,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_result,
    input  logic                     add_carry,
    input  logic                     add_zero,
    input  logic                     add_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic                     out_overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_sticky
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            nonempty;
    logic            push;
    logic            load;

    assign nonempty = (count != '0);
    // Ready looks only at occupancy so it never waits on the downstream ready.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign load     = nonempty && (!out_valid || out_ready);

    assign head     = mem[rd_ptr];
    assign add_a    = nonempty ? head.a   : '0;
    assign add_b    = nonempty ? head.b   : '0;
    assign add_cin  = nonempty ? head.sub : 1'b0;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{a: in_a, b: in_b, sub: in_sub};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (load)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_result   <= add_result;
            out_carry    <= add_carry;
            out_zero     <= add_zero;
            out_overflow <= add_overflow;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (out_valid && out_ready && out_overflow)
            ovf_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_addsub_issue.sv
// Randomized and directed bench for addsub_issue; a scoreboard of pushed operations
// is checked against results computed with wide signed/unsigned integer arithmetic.
module tb_addsub_issue;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_sub;
    logic [W-1:0]  in_a, in_b;
    logic [W-1:0]  add_a, add_b, add_result;
    logic          add_cin, add_carry, add_zero, add_overflow;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_result;
    logic          out_carry, out_zero, out_overflow;
    logic [CW-1:0] count;
    logic          ovf_sticky;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } op_t;

    op_t          sb[$];
    logic         mdl_sticky = 1'b0;
    logic         hold_vld = 1'b0;
    logic [W-1:0] held;

    always #5 clk = ~clk;

    addsub_issue #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_result(add_result), .add_carry(add_carry),
        .add_zero(add_zero), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry),
        .out_zero(out_zero), .out_overflow(out_overflow),
        .count(count), .ovf_sticky(ovf_sticky)
    );

    // External adder: one's-complement of b plus carry-in for subtract.
    logic [W-1:0] bx;
    always_comb begin
        bx = add_b ^ {W{add_cin}};
        {add_carry, add_result} = {1'b0, add_a} + {1'b0, bx} + {{W{1'b0}}, add_cin};
        add_zero     = (add_result == '0);
        add_overflow = (add_a[W-1] == bx[W-1]) && (add_result[W-1] != add_a[W-1]);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input op_t o, output logic [W-1:0] r,
                                  output logic c, output logic z, output logic v);
        longint ua, ub, sa, sb2, ur, sr;
        ua  = longint'(o.a);
        ub  = longint'(o.b);
        sa  = longint'($signed(o.a));
        sb2 = longint'($signed(o.b));
        if (o.sub) begin
            ur = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb2;
        end else begin
            ur = ua + ub;
            c  = ur[32];
            sr = sa + sb2;
        end
        r = ur[W-1:0];
        z = (r == '0);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endfunction

    // Handshakes seen at negedge are the ones the next rising edge will take.
    always @(negedge clk) begin
        op_t          o;
        logic [W-1:0] er;
        logic         ec, ez, ev;
        if (!rst_n) begin
            sb.delete();
            mdl_sticky = 1'b0;
            hold_vld   = 1'b0;
        end else begin
            chk("ovf_sticky", ovf_sticky, mdl_sticky);
            chk("in_ready", in_ready, count < CW'(D));
            if (hold_vld) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_result", out_result, held);
            end
            hold_vld = out_valid && !out_ready;
            held     = out_result;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    o = sb.pop_front();
                    model(o, er, ec, ez, ev);
                    chk("result", out_result, er);
                    chk("carry", out_carry, ec);
                    chk("zero", out_zero, ez);
                    chk("overflow", out_overflow, ev);
                    if (ev) mdl_sticky = 1'b1;
                    n_done++;
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{in_a, in_b, in_sub});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc, base;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, '0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        rst_n = 1'b1;
        tick();

        // add 5 + 7
        out_ready = 1'b1;
        drive(5, 7, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("add_count", count, 1);
        chk("add_vld_early", out_valid, 1'b0);
        tick();
        chk("add_vld", out_valid, 1'b1);
        chk("add_res", out_result, 12);
        chk("add_flags", {out_carry, out_zero, out_overflow}, 3'b000);
        tick();

        // sub 5 - 5
        drive(5, 5, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("sub_vld", out_valid, 1'b1);
        chk("sub_res", out_result, 0);
        chk("sub_flags", {out_carry, out_zero, out_overflow}, 3'b110);
        tick();

        // signed overflow
        drive(32'h7FFF_FFFF, 1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("ovf_res", out_result, 32'h8000_0000);
        chk("ovf_flag", out_overflow, 1'b1);
        tick();
        chk("ovf_sticky_set", ovf_sticky, 1'b1);
        repeat (3) tick();
        chk("ovf_sticky_hold", ovf_sticky, 1'b1);

        // backpressure fills the queue plus the output register
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(32'(100 + acc), 32'(acc), acc[0]);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_count", count, 4);
        chk("bp_in_ready", in_ready, 1'b0);
        base = n_done;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_stream_vld", out_valid, 1'b1);
            tick();
        end
        chk("bp_drained_vld", out_valid, 1'b0);
        chk("bp_drained_cnt", count, 0);
        chk("bp_delivered", n_done - base, 5);

        // continuous streaming at full rate
        base = n_done;
        for (int i = 0; i < 10; i++) begin
            drive(rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
            tick();
            chk("stream_count_le1", count <= 1, 1'b1);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_delivered", n_done - base, 10);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rnd_opnd();
            in_b      = rnd_opnd();
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) tick();
        chk("rand_drained", sb.size(), 0);

        // reset in the middle of a backlog
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'(i + 1), 32'(i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        chk("mid_count", count, 3);
        chk("mid_vld", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_sticky", ovf_sticky, 1'b0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            tick();
            chk("post_rst_idle", out_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
